fetch_control: RTL and testbench

FETCH_CONTROL -- requirements
Module: fetch_control

---
 rtl/fetch_control.sv | 168 ++++++++++++++++
 tb/tb_fetch_control.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// Instruction fetch front end: drives a single-outstanding instruction memory
// port and fills the IF/ID pipeline register. Handles stalls, redirects and wait states.
module fetch_control #(
  parameter logic [8:0] RESET_PC = 9'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [8:0]  PCTargetE,
  input  logic        StallD,
  output logic        imem_req,
  output logic [8:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [8:0]  PCD,
  output logic [8:0]  PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [8:0]  r_pcf;
  logic [8:0]  w_pcf_nxt;
  logic [8:0]  r_drain_addr;
  logic [8:0]  w_drain_addr_nxt;

  logic [31:0] r_skid_instr;
  logic [31:0] w_skid_instr_nxt;
  logic [8:0]  r_skid_pc;
  logic [8:0]  w_skid_pc_nxt;

  logic [31:0] r_instr_d;
  logic [31:0] w_instr_d_nxt;
  logic [8:0]  r_pc_d;
  logic [8:0]  w_pc_d_nxt;
  logic [8:0]  r_pc_plus4_d;
  logic [8:0]  w_pc_plus4_d_nxt;
  logic        r_valid_d;
  logic        w_valid_d_nxt;

  logic        w_req_active;
  logic        w_ack;
  logic [8:0]  w_pcf_plus4;
  logic [8:0]  w_skid_pc_plus4;

  // The request is gated by rst so an abandoned transaction is dropped immediately.
  assign w_req_active    = (r_state == S_REQ) || (r_state == S_DRAIN);
  assign imem_req        = w_req_active && !rst;
  assign imem_addr       = (r_state == S_DRAIN) ? r_drain_addr : r_pcf;
  assign w_ack           = imem_ack && imem_req;
  assign w_pcf_plus4     = r_pcf + 9'd4;
  assign w_skid_pc_plus4 = r_skid_pc + 9'd4;

  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc_plus4_d;
  assign ValidD   = r_valid_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_state_nxt      = r_state;
    w_pcf_nxt        = r_pcf;
    w_drain_addr_nxt = r_drain_addr;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_instr_d_nxt    = r_instr_d;
    w_pc_d_nxt       = r_pc_d;
    w_pc_plus4_d_nxt = r_pc_plus4_d;
    w_valid_d_nxt    = r_valid_d;

    // Decode consumes the current instruction whenever it is not stalled.
    if (!StallD) begin
      w_valid_d_nxt = 1'b0;
    end

    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end

      S_REQ: begin
        if (w_ack) begin
          if (!PCSrcE) begin
            w_pcf_nxt = w_pcf_plus4;
            if (StallD && r_valid_d) begin
              w_skid_instr_nxt = imem_rdata;
              w_skid_pc_nxt    = r_pcf;
              w_state_nxt      = S_HOLD;
            end else begin
              w_instr_d_nxt    = imem_rdata;
              w_pc_d_nxt       = r_pcf;
              w_pc_plus4_d_nxt = w_pcf_plus4;
              w_valid_d_nxt    = 1'b1;
            end
          end
        end else if (PCSrcE) begin
          // The memory still owes a response for the old address; wait it out.
          w_drain_addr_nxt = r_pcf;
          w_state_nxt      = S_DRAIN;
        end
      end

      S_HOLD: begin
        if (!StallD) begin
          w_instr_d_nxt    = r_skid_instr;
          w_pc_d_nxt       = r_skid_pc;
          w_pc_plus4_d_nxt = w_skid_pc_plus4;
          w_valid_d_nxt    = 1'b1;
          w_state_nxt      = S_REQ;
        end
      end

      S_DRAIN: begin
        if (w_ack) begin
          w_state_nxt = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A redirect beats stalls and any word returning this cycle.
    if (PCSrcE) begin
      w_pcf_nxt     = PCTargetE;
      w_valid_d_nxt = 1'b0;
      if (r_state == S_IDLE || r_state == S_HOLD) begin
        w_state_nxt = S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      r_state      <= S_IDLE;
      r_pcf        <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 9'd0;
      r_instr_d    <= 32'd0;
      r_pc_d       <= 9'd0;
      r_pc_plus4_d <= 9'd0;
      r_valid_d    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pcf        <= w_pcf_nxt;
      r_drain_addr <= w_drain_addr_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_instr_d    <= w_instr_d_nxt;
      r_pc_d       <= w_pc_d_nxt;
      r_pc_plus4_d <= w_pc_plus4_d_nxt;
      r_valid_d    <= w_valid_d_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: a memory model plus a scoreboard of
// accepted fetches, compared against IF/ID whenever decode consumes an instruction.
module tb_fetch_control;

  localparam logic [8:0] RESET_PC = 9'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [8:0]  PCTargetE;
  logic        StallD;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [8:0]  PCD;
  logic [8:0]  PCPlus4D;
  logic        ValidD;

  fetch_control #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .StallD     (StallD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return {16'hC0DE, 7'h15, a};
  endfunction

  // Memory model: force_ack answers every cycle (even without a request);
  // otherwise the ack arrives once the request has waited ack_delay cycles.
  logic force_ack;
  int   ack_delay;
  int   wait_cnt = 0;

  assign imem_rdata = mem_word(imem_addr);
  assign imem_ack   = force_ack || (imem_req && (wait_cnt >= ack_delay));

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [8:0]  pc;
    logic [31:0] instr;
  } exp_t;

  exp_t       sb_q[$];
  logic [8:0] exp_pc       = RESET_PC;
  logic       drop_pending = 1'b0;
  logic       prev_pending = 1'b0;
  logic [8:0] prev_addr    = 9'd0;

  // Sampled mid-cycle: inputs and outputs are stable and describe the coming edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] e_plus4;
    if (rst) begin
      sb_q.delete();
      exp_pc       = RESET_PC;
      drop_pending = 1'b0;
      prev_pending = 1'b0;
    end else begin
      if (ValidD && !StallD) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", sb_q.size(), 1);
        end else begin
          e       = sb_q.pop_front();
          e_plus4 = e.pc + 9'd4;
          check("PCD", PCD, e.pc);
          check("InstrD", InstrD, e.instr);
          check("PCPlus4D", PCPlus4D, e_plus4);
          pops++;
        end
      end
      if (imem_req && prev_pending) check("addr_stable", imem_addr, prev_addr);
      if (imem_req && imem_ack) begin
        if (PCSrcE || drop_pending) begin
          drop_pending = 1'b0;
        end else begin
          check("imem_addr", imem_addr, exp_pc);
          e.pc    = exp_pc;
          e.instr = mem_word(exp_pc);
          sb_q.push_back(e);
          exp_pc  = exp_pc + 9'd4;
        end
      end else if (imem_req && PCSrcE) begin
        drop_pending = 1'b1;
      end
      if (PCSrcE) begin
        sb_q.delete();
        exp_pc = PCTargetE;
      end
      prev_pending = imem_req && !imem_ack;
      prev_addr    = imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    force_ack = 1'b1;
    ack_delay = 0;
    rst       = 1'b1;
    PCSrcE    = 1'b0;
    StallD    = 1'b0;
    PCTargetE = 9'd0;

    // Reset state, with a spurious ack present.
    tick();
    tick();
    check("rst_valid", ValidD, 1'b0);
    check("rst_pcd", PCD, 9'd0);
    check("rst_instr", InstrD, 32'd0);
    check("rst_pcplus4", PCPlus4D, 9'd0);
    check("rst_req", imem_req, 1'b0);

    // Back-to-back fetch with ack tied high.
    rst = 1'b0;
    tick();
    check("idle_valid", ValidD, 1'b0);
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, RESET_PC);
    repeat (6) tick();
    check("stream_pcd", PCD, 9'h014);
    check("stream_pops", pops, 5);

    // Three-cycle memory latency: one ValidD pulse per request.
    force_ack = 1'b0;
    ack_delay = 2;
    p0 = pops;
    repeat (12) tick();
    check("slow_pops", pops - p0, 4);
    check("slow_pcd", PCD, 9'h024);
    check("slow_valid", ValidD, 1'b1);

    // Four-cycle stall while fetching address 8.
    force_ack = 1'b1;
    ack_delay = 0;
    do_reset();
    repeat (3) tick();
    check("pre_stall_pcd", PCD, 9'h004);
    StallD = 1'b1;
    repeat (4) begin
      tick();
      check("stall_pcd", PCD, 9'h004);
      check("stall_valid", ValidD, 1'b1);
      check("hold_req", imem_req, 1'b0);
    end
    StallD = 1'b0;
    tick();
    check("unstall_pcd", PCD, 9'h008);
    check("unstall_valid", ValidD, 1'b1);
    check("unstall_addr", imem_addr, 9'h00C);
    tick();
    check("after_skid_pcd", PCD, 9'h00C);

    // Redirect with a request outstanding, then a second redirect during the drain.
    force_ack = 1'b0;
    ack_delay = 1000;
    do_reset();
    repeat (3) tick();
    PCSrcE    = 1'b1;
    PCTargetE = 9'h100;
    tick();
    check("drain_req", imem_req, 1'b1);
    check("drain_addr", imem_addr, 9'h000);
    check("drain_valid", ValidD, 1'b0);
    PCTargetE = 9'h040;
    tick();
    PCSrcE = 1'b0;
    tick();
    check("drain_addr_held", imem_addr, 9'h000);
    ack_delay = 0;
    tick();
    check("redir_addr", imem_addr, 9'h040);
    check("redir_valid", ValidD, 1'b0);
    tick();
    check("redir_pcd", PCD, 9'h040);
    check("redir_valid2", ValidD, 1'b1);

    // Redirect and stall together, landing at the top of the address space.
    force_ack = 1'b1;
    StallD    = 1'b1;
    PCSrcE    = 1'b1;
    PCTargetE = 9'h1FC;
    tick();
    check("redir_stall_valid", ValidD, 1'b0);
    StallD = 1'b0;
    PCSrcE = 1'b0;
    tick();
    check("wrap_pcd0", PCD, 9'h1FC);
    check("wrap_plus4", PCPlus4D, 9'h000);
    tick();
    check("wrap_pcd1", PCD, 9'h000);
    check("wrap_valid", ValidD, 1'b1);

    // Reset in the middle of a drain; the ack right after reset must be ignored.
    force_ack = 1'b0;
    ack_delay = 1000;
    tick();
    PCSrcE    = 1'b1;
    PCTargetE = 9'h020;
    tick();
    PCSrcE = 1'b0;
    check("pre_rst_drain_req", imem_req, 1'b1);
    rst       = 1'b1;
    force_ack = 1'b1;
    tick();
    check("mid_rst_valid", ValidD, 1'b0);
    check("mid_rst_req", imem_req, 1'b0);
    rst = 1'b0;
    tick();
    check("restart_req", imem_req, 1'b1);
    check("restart_addr", imem_addr, RESET_PC);
    check("restart_valid", ValidD, 1'b0);
    tick();
    check("restart_pcd", PCD, RESET_PC);
    check("restart_valid2", ValidD, 1'b1);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
